mips_data_bus: RTL and testbench



---
 rtl/mips_data_bus.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_data_bus.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_bus.sv
// rtl/mips_data_bus.sv - MIPS load/store data bus: word RAM, output port registers, synchronized input port.
module mips_data_bus #(
  parameter int unsigned DATA_DEPTH    = 1024,
  parameter logic [31:0] DATA_BASE     = 32'h1001_0000,
  parameter logic [31:0] IO_BASE       = 32'hFFFF_0000,
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned PORT_IN_WIDTH = 8,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic                         resp_error,
  input  logic [PORT_IN_WIDTH-1:0]     port_in,
  output logic [32*NUM_OUT_PORTS-1:0]  port_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned PIDX_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_DEPTH);
  localparam logic [31:0] OUT_BYTES = 32'(4 * NUM_OUT_PORTS);
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] port_q [NUM_OUT_PORTS];
  logic [31:0] port_d [NUM_OUT_PORTS];
  logic [PORT_IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0] mem_q [DATA_DEPTH];

  logic              eff_write, eff_unsigned;
  logic [1:0]        eff_size;
  logic [31:0]       eff_addr, eff_wdata;
  logic [31:0]       ram_off, io_off, in_ext, cur_word, store_word, load_val;
  logic              hit_ram, hit_out, hit_in, acc_err, go_resp, mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [PIDX_W-1:0] port_idx;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{a, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_lanes(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] a, input logic uns);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // In IDLE the live request is decoded so a zero-wait access can commit on its acceptance edge.
  always_comb begin
    eff_write    = (state_q == S_IDLE) ? req_write    : wr_q;
    eff_size     = (state_q == S_IDLE) ? req_size     : size_q;
    eff_unsigned = (state_q == S_IDLE) ? req_unsigned : uns_q;
    eff_addr     = (state_q == S_IDLE) ? req_addr     : addr_q;
    eff_wdata    = (state_q == S_IDLE) ? req_wdata    : wdata_q;

    ram_off  = eff_addr - DATA_BASE;
    io_off   = eff_addr - IO_BASE;
    hit_ram  = (eff_addr >= DATA_BASE) && (ram_off < RAM_BYTES);
    hit_out  = !hit_ram && (eff_addr >= IO_BASE) && (io_off < OUT_BYTES);
    hit_in   = !hit_ram && !hit_out && (eff_addr >= IO_BASE) && (io_off[31:2] == 30'h40);
    mem_idx  = ram_off[IDX_W+1:2];
    port_idx = io_off[PIDX_W+1:2];

    in_ext = '0;
    in_ext[PORT_IN_WIDTH-1:0] = sync2_q;

    if (hit_ram)      cur_word = mem_q[mem_idx];
    else if (hit_out) cur_word = port_q[port_idx];
    else if (hit_in)  cur_word = in_ext;
    else              cur_word = '0;

    acc_err = !(hit_ram || hit_out || hit_in)
            || (eff_size == 2'b11)
            || ((eff_size == 2'b01) && eff_addr[0])
            || ((eff_size == 2'b10) && (eff_addr[1:0] != 2'b00))
            || (eff_write && hit_in);

    store_word = merge_lanes(cur_word, eff_wdata, eff_size, eff_addr[1:0]);
    load_val   = extract_lanes(cur_word, eff_size, eff_addr[1:0], eff_unsigned);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    port_d  = port_q;
    sync1_d = port_in;
    sync2_d = sync1_q;
    go_resp = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Stores and load data both resolve on the edge that enters RESP.
    if (go_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || eff_write) ? 32'd0 : load_val;
      if (!acc_err && eff_write) begin
        if (hit_ram) mem_we = !reset;
        if (hit_out) port_d[port_idx] = store_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) port_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      port_q  <= port_d;
    end
  end

  // RAM has no reset; mem_we already excludes a reset cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= store_word;
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_port_out
    assign port_out[32*k +: 32] = port_q[k];
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

endmodule

// File: tb/tb_mips_data_bus.sv
// tb/tb_mips_data_bus.sv - scoreboard bench for mips_data_bus with one-wait and zero-wait instances.
module tb_mips_data_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [7:0]  port_in = 8'h00;
  logic [63:0] port_out;

  logic        req_valid0 = 1'b0, req_write0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic        req_ready0, resp_valid0, resp_error0;
  logic [31:0] resp_rdata0;
  logic [63:0] port_out0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb_q[$];
  exp_t sb0_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acc0     = 0;
  int resp0    = 0;

  always #5 clk = ~clk;

  mips_data_bus dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .port_in(port_in), .port_out(port_out)
  );

  mips_data_bus #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_size(2'b10), .req_unsigned(1'b0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_error(resp_error0), .port_in(8'h00), .port_out(port_out0)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        check32("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check32("resp_rdata", resp_rdata, e.rdata);
        check32("resp_error", {31'd0, resp_error}, {31'd0, e.err});
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && req_valid0 && req_ready0) begin
      exp_t e;
      acc0++;
      e.rdata = req_write0 ? 32'd0 : 32'h0BAD_CAFE;
      e.err   = 1'b0;
      sb0_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset && resp_valid0) begin
      resp0++;
      if (sb0_q.size() == 0) begin
        check32("unexpected_resp0", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb0_q.pop_front();
        check32("resp0_rdata", resp_rdata0, e.rdata);
        check32("resp0_error", {31'd0, resp_error0}, {31'd0, e.err});
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int guard;
    int lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check32("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_unsigned = ~u;
    req_addr = 32'h0; req_wdata = ~wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check32("latency", 32'(lat), 32'd2);
  endtask

  task automatic reset_during_store(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("rst_ready", {31'd0, req_ready}, 32'd1);
    check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("rst_port_out_lo", port_out[31:0], 32'd0);
    check32("rst_port_out_hi", port_out[63:32], 32'd0);
    @(negedge clk);
    check32("rst_no_late_resp", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check32("reset_ready", {31'd0, req_ready}, 32'd1);
    check32("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("reset_resp_error", {31'd0, resp_error}, 32'd0);
    check32("reset_resp_rdata", resp_rdata, 32'd0);
    check32("reset_port_out", port_out[31:0] | port_out[63:32], 32'd0);

    // word store/load, then byte lanes over a zeroed word
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h0000_0000, 32'd0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h1001_0007, 32'h1234_5680, 32'd0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h1001_0007, 32'd0, 32'hFFFF_FF80, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'd0, 32'h0000_0080, 1'b0);
    do_req(1'b0, 2'b10, 1'b1, 32'h1001_0004, 32'd0, 32'h8000_0000, 1'b0);

    // half store into upper lanes: 0x80000000 -> 0xBEEF0000
    do_req(1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'hAAAA_BEEF, 32'd0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'd0, 32'hFFFF_BEEF, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'd0, 32'h0000_BEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 32'hBEEF_0000, 1'b0);

    // faults leave state untouched
    do_req(1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'd0, 32'd0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h5555_5555, 32'd0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0006, 32'h5555_5555, 32'd0, 1'b1);
    do_req(1'b1, 2'b11, 1'b0, 32'h1001_0004, 32'h5555_5555, 32'd0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 32'hBEEF_0000, 1'b0);

    // RAM region boundary
    do_req(1'b1, 2'b10, 1'b0, 32'h1001_0FFC, 32'hA5A5_5A5A, 32'd0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0FFC, 32'd0, 32'hA5A5_5A5A, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'd0, 32'd0, 1'b1);

    // output ports
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_0004, 32'h1234_5678, 32'd0, 1'b0);
    check32("port1_in_resp", port_out[63:32], 32'h1234_5678);
    check32("port0_untouched", port_out[31:0], 32'd0);
    do_req(1'b1, 2'b00, 1'b0, 32'hFFFF_0005, 32'h0000_00AB, 32'd0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_0004, 32'd0, 32'h1234_AB78, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_0100, 32'h1111_1111, 32'd0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_0008, 32'h1111_1111, 32'd0, 1'b1);
    check32("port1_after_faults", port_out[63:32], 32'h1234_AB78);

    // input port through the synchronizer
    @(negedge clk);
    port_in = 8'hA5;
    repeat (3) @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_0100, 32'd0, 32'h0000_00A5, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF_0100, 32'd0, 32'hFFFF_FFA5, 1'b0);

    // reset in WAIT discards the store; RAM survives reset
    reset_during_store(32'hFFFF_0000, 32'hCAFE_F00D);
    reset_during_store(32'h1001_0004, 32'h1111_1111);
    do_req(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'd0, 32'hBEEF_0000, 1'b0);
    check32("port_out_after_reset", port_out[63:32], 32'd0);

    // zero-wait instance: request held every cycle, accepted every other cycle
    @(negedge clk);
    acc0 = 0;
    resp0 = 0;
    req_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_write0 = (acc0 == 0);
      req_addr0  = 32'h1001_0000;
      req_wdata0 = 32'h0BAD_CAFE;
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    check32("ws0_accepts", 32'(acc0), 32'd5);
    check32("ws0_responses", 32'(resp0), 32'd5);

    check32("sb_drained", 32'(sb_q.size()), 32'd0);
    check32("sb0_drained", 32'(sb0_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
